// File: rtl/vec_alu_seq.sv
// Multi-cycle element-wise vector ALU (add/sub/signed mul), LANES elements per beat.
// Define VEC_ALU_MAC_EN to make op=11 a multiply-accumulate into the result registers.
module vec_alu_seq #(
  parameter int DATA_W = 32,
  parameter int VLEN   = 16,
  parameter int LANES  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [VLEN*DATA_W-1:0]   a_vec,
  input  logic [VLEN*DATA_W-1:0]   b_vec,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [VLEN*DATA_W-1:0]   res_lo,
  output logic [VLEN*DATA_W-1:0]   res_hi
);

  localparam int NBEATS = VLEN / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int RW     = 2 * DATA_W;
  localparam int VW     = VLEN * DATA_W;

  localparam logic [BW-1:0] LAST = BW'(NBEATS - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (VLEN % LANES != 0) begin : g_bad_lanes
      $error("vec_alu_seq: VLEN must be a multiple of LANES");
    end
  endgenerate

  logic [0:0]    state;
  logic [BW-1:0] beat;
  logic [1:0]    op_q;
  logic [VW-1:0] a_q;
  logic [VW-1:0] b_q;
  logic          legal;

  logic signed [RW-1:0] ea   [LANES];
  logic signed [RW-1:0] eb   [LANES];
  logic        [RW-1:0] nres [LANES];

`ifdef VEC_ALU_MAC_EN
  assign legal = 1'b1;
`else
  assign legal = (op != 2'b11);
`endif

  assign busy = (state == RUN);

  // Per-lane datapath for the elements selected by the current beat
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      int                   idx;
      logic [DATA_W-1:0]    av;
      logic [DATA_W-1:0]    bv;
      logic signed [RW-1:0] prod;
      logic [RW-1:0]        acc;
      idx  = int'(beat) * LANES + l;
      av   = a_q[idx*DATA_W +: DATA_W];
      bv   = b_q[idx*DATA_W +: DATA_W];
      ea[l] = {{DATA_W{av[DATA_W-1]}}, av};
      eb[l] = {{DATA_W{bv[DATA_W-1]}}, bv};
      prod = ea[l] * eb[l];
      acc  = {res_hi[idx*DATA_W +: DATA_W],
              res_lo[idx*DATA_W +: DATA_W]};
      case (op_q)
        2'b00:   nres[l] = ea[l] + eb[l];
        2'b01:   nres[l] = ea[l] - eb[l];
        2'b10:   nres[l] = prod;
`ifdef VEC_ALU_MAC_EN
        default: nres[l] = acc + prod;
`else
        default: nres[l] = prod ^ (acc & '0);
`endif
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              a_q   <= a_vec;
              b_q   <= b_vec;
              op_q  <= op;
              beat  <= '0;
              state <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            res_lo[(int'(beat)*LANES+l)*DATA_W +: DATA_W] <= nres[l][DATA_W-1:0];
            res_hi[(int'(beat)*LANES+l)*DATA_W +: DATA_W] <= nres[l][RW-1:DATA_W];
          end
          if (beat == LAST) begin
            beat  <= '0;
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            beat <= beat + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq (DATA_W=32, VLEN=16, LANES=4).
// Expected vectors come from a reference model of the result registers.
module tb_vec_alu_seq;

  localparam int DW   = 32;
  localparam int VLEN = 16;
  localparam int NB   = 4;
  localparam int VW   = VLEN * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [VW-1:0] a_vec;
  logic [VW-1:0] b_vec;
  logic          busy;
  logic          done;
  logic          err;
  logic [VW-1:0] res_lo;
  logic [VW-1:0] res_hi;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [VW-1:0] lo;
    logic [VW-1:0] hi;
  } exp_t;

  exp_t          sb[$];
  logic [VW-1:0] m_lo;
  logic [VW-1:0] m_hi;

  vec_alu_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_vec  (a_vec),
    .b_vec  (b_vec),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .res_lo (res_lo),
    .res_hi (res_hi)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [63:0] acc);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'b00:   return sx + sy;
      2'b01:   return sx - sy;
      2'b10:   return sx * sy;
      default: return acc + sx * sy;
    endcase
  endfunction

  function automatic logic [VW-1:0] fill(input logic [31:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < VLEN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [63:0] elem(input int i);
    return {res_hi[i*DW +: DW], res_lo[i*DW +: DW]};
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VLEN; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic push_exp(input logic [1:0] o,
                          input logic [VW-1:0] a,
                          input logic [VW-1:0] b);
    exp_t e;
    for (int i = 0; i < VLEN; i++) begin
      logic [63:0] r;
      r = model(o, a[i*DW +: DW], b[i*DW +: DW],
                {m_hi[i*DW +: DW], m_lo[i*DW +: DW]});
      m_lo[i*DW +: DW] = r[31:0];
      m_hi[i*DW +: DW] = r[63:32];
    end
    e.lo = m_lo;
    e.hi = m_hi;
    sb.push_back(e);
  endtask

  // Drive start at a negedge; returns at the negedge after the launch edge
  task automatic launch(input logic [1:0] o,
                        input logic [VW-1:0] a,
                        input logic [VW-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_vec = a;
    b_vec = b;
    push_exp(o, a, b);
    @(negedge clk);
    start = 1'b0;
    a_vec = rnd_vec();
    b_vec = rnd_vec();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL launch_busy got=%b want=1", busy);
    else n_pass++;
  endtask

  task automatic wait_done(input bit poke);
    int   lat;
    int   bad_busy;
    exp_t e;
    lat      = 0;
    bad_busy = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (poke && (lat == 1 || lat == 2)) begin
        start = 1'b1;
        op    = 2'b00;
        a_vec = rnd_vec();
      end else begin
        start = 1'b0;
      end
      if ((lat < NB && busy !== 1'b1) || (lat >= NB && busy !== 1'b0))
        bad_busy++;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    n_chk++;
    if (done !== 1'b1) begin
      $display("FAIL done_timeout got=%b want=1 after %0d cycles", done, lat);
      return;
    end else n_pass++;
    n_chk++;
    if (lat !== NB) $display("FAIL latency got=%0d want=%0d", lat, NB);
    else n_pass++;
    n_chk++;
    if (bad_busy !== 0) $display("FAIL busy_window got=%0d bad cycles want=0", bad_busy);
    else n_pass++;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL sb_empty got=0 entries want>=1");
      return;
    end else n_pass++;
    e = sb.pop_front();
    n_chk++;
    if (res_lo !== e.lo) $display("FAIL sb_lo got=%h want=%h", res_lo, e.lo);
    else n_pass++;
    n_chk++;
    if (res_hi !== e.hi) $display("FAIL sb_hi got=%h want=%h", res_hi, e.hi);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'($urandom);
      op    = 2'($urandom);
      a_vec = rnd_vec();
      b_vec = rnd_vec();
    end
    start = 1'b0;
    rst   = 1'b0;
    m_lo  = '0;
    m_hi  = '0;
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy);
    else n_pass++;
    n_chk++;
    if (done !== 1'b0) $display("FAIL rst_done got=%b want=0", done);
    else n_pass++;
    n_chk++;
    if (err !== 1'b0) $display("FAIL rst_err got=%b want=0", err);
    else n_pass++;
    n_chk++;
    if (res_lo !== '0 || res_hi !== '0)
      $display("FAIL rst_res got=%h/%h want=0", res_hi, res_lo);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [VW-1:0] a;
    for (int i = 0; i < VLEN; i++) a[i*DW +: DW] = i;
    launch(2'b00, a, fill(32'hFFFFFFFF));
    wait_done(1'b0);
    n_chk++;
    if (elem(0) !== 64'hFFFFFFFF_FFFFFFFF)
      $display("FAIL add_e0 got=%h want=ffffffffffffffff", elem(0));
    else n_pass++;
    n_chk++;
    if (elem(5) !== 64'h4) $display("FAIL add_e5 got=%h want=4", elem(5));
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) $display("FAIL add_done_pulse got=%b want=0", done);
    else n_pass++;
  endtask

  task automatic test_mul_sub();
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    a = rnd_vec();
    b = rnd_vec();
    a[0 +: DW]  = 32'h80000000;
    b[0 +: DW]  = 32'h80000000;
    a[DW +: DW] = -32'sd3;
    b[DW +: DW] = 32'd7;
    launch(2'b10, a, b);
    wait_done(1'b0);
    n_chk++;
    if (elem(0) !== 64'h40000000_00000000)
      $display("FAIL mul_e0 got=%h want=4000000000000000", elem(0));
    else n_pass++;
    n_chk++;
    if (elem(1) !== 64'hFFFFFFFF_FFFFFFEB)
      $display("FAIL mul_e1 got=%h want=ffffffffffffffeb", elem(1));
    else n_pass++;
    launch(2'b01, fill(32'd5), fill(32'd9));
    wait_done(1'b0);
    n_chk++;
    if (elem(9) !== 64'hFFFFFFFF_FFFFFFFC)
      $display("FAIL sub_e9 got=%h want=fffffffffffffffc", elem(9));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int extra;
    launch(2'b10, rnd_vec(), rnd_vec());
    wait_done(1'b1);
    // done cycle: start is accepted here
    start = 1'b1;
    op    = 2'b00;
    a_vec = rnd_vec();
    b_vec = rnd_vec();
    push_exp(2'b00, a_vec, b_vec);
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) $display("FAIL b2b_busy got=%b want=1", busy);
    else n_pass++;
    wait_done(1'b0);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_chk++;
    if (extra !== 0) $display("FAIL b2b_extra got=%0d want=0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    launch(2'b10, rnd_vec(), rnd_vec());
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || res_lo !== '0 || res_hi !== '0)
      $display("FAIL midrst got busy=%b lo=%h hi=%h want 0", busy, res_lo, res_hi);
    else n_pass++;
    @(negedge clk);
    rst  = 1'b0;
    sb.delete();
    m_lo = '0;
    m_hi = '0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL midrst_done got=%0d want=0", seen);
    else n_pass++;
  endtask

`ifdef VEC_ALU_MAC_EN
  task automatic test_mac();
    launch(2'b10, fill(32'd2), fill(32'd3));
    wait_done(1'b0);
    launch(2'b11, fill(32'd4), fill(32'd5));
    wait_done(1'b0);
    n_chk++;
    if (elem(7) !== 64'd26) $display("FAIL mac_e7 got=%h want=1a", elem(7));
    else n_pass++;
    launch(2'b10, fill(32'h80000000), fill(32'h80000000));
    wait_done(1'b0);
    launch(2'b11, fill(32'h80000000), fill(32'h80000001));
    wait_done(1'b0);
    launch(2'b11, fill(32'h7FFFFFFF), fill(32'd1));
    wait_done(1'b0);
    n_chk++;
    if (elem(3) !== 64'h7FFFFFFF_FFFFFFFF)
      $display("FAIL mac_max got=%h want=7fffffffffffffff", elem(3));
    else n_pass++;
    launch(2'b11, fill(32'd1), fill(32'd1));
    wait_done(1'b0);
    n_chk++;
    if (elem(3) !== 64'h80000000_00000000)
      $display("FAIL mac_wrap got=%h want=8000000000000000", elem(3));
    else n_pass++;
  endtask
`else
  task automatic test_illegal();
    launch(2'b00, fill(32'd10), fill(32'd20));
    wait_done(1'b0);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    a_vec = rnd_vec();
    b_vec = rnd_vec();
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (err !== 1'b1) $display("FAIL ill_err got=%b want=1", err);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL ill_busy got=%b want=0", busy);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0 || busy !== 1'b0)
      $display("FAIL ill_pulse got err=%b busy=%b want 0/0", err, busy);
    else n_pass++;
    n_chk++;
    if (res_lo !== m_lo || res_hi !== m_hi)
      $display("FAIL ill_hold got=%h/%h want=%h/%h", res_hi, res_lo, m_hi, m_lo);
    else n_pass++;
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a_vec = '0;
    b_vec = '0;
    m_lo  = '0;
    m_hi  = '0;
    test_reset();
    test_add();
    test_mul_sub();
    test_back_to_back();
    test_reset_mid();
`ifdef VEC_ALU_MAC_EN
    test_mac();
`else
    test_illegal();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
